// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes the opcode, extends the immediate and buffers results in a
// 2-entry FIFO. Define IMM_GEN_PERF_EN to build the saturating input-stall counter.
module imm_gen_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_instr,
    output logic [15:0]      out_imm,
    output logic             out_has_imm,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        Len5  = 2'b00,
        Len8  = 2'b01,
        Len11 = 2'b10
    } len_e;

    logic [4:0]  op;
    len_e        length_in;
    logic        ext_type;  // 1 = sign-extend, 0 = zero-extend
    logic        dec_has_imm;
    logic [15:0] dec_imm;

    assign op = in_instr[15:11];

    always_comb begin
        length_in   = Len5;
        ext_type    = 1'b0;
        dec_has_imm = 1'b1;
        case (op)
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                length_in = Len5;
                ext_type  = 1'b1;
            end
            5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                length_in = Len5;
                ext_type  = 1'b0;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111: begin
                length_in = Len8;
                ext_type  = 1'b1;
            end
            5'b10010: begin
                length_in = Len8;
                ext_type  = 1'b0;
            end
            5'b00100, 5'b00110: begin
                length_in = Len11;
                ext_type  = 1'b1;
            end
            default: dec_has_imm = 1'b0;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        if (dec_has_imm) begin
            case (length_in)
                Len5:    dec_imm = {{11{ext_type & in_instr[4]}}, in_instr[4:0]};
                Len8:    dec_imm = {{8{ext_type & in_instr[7]}}, in_instr[7:0]};
                Len11:   dec_imm = {{5{ext_type & in_instr[10]}}, in_instr[10:0]};
                default: dec_imm = '0;
            endcase
        end
    end

    logic [15:0] instr_mem [DEPTH];
    logic [15:0] imm_mem   [DEPTH];
    logic        has_mem   [DEPTH];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        enq, deq;

    // No pass-through when full: a same-cycle dequeue does not free a slot for enqueue.
    assign in_ready  = ~rst & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            instr_mem[0] <= '0;
            imm_mem[0]   <= '0;
            has_mem[0]   <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (enq) begin
                instr_mem[wr_ptr_q] <= in_instr;
                imm_mem[wr_ptr_q]   <= dec_imm;
                has_mem[wr_ptr_q]   <= dec_has_imm;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Stale storage must never leak onto the outputs while the FIFO is empty.
    assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_imm     = out_valid ? imm_mem[rd_ptr_q] : '0;
    assign out_has_imm = out_valid & has_mem[rd_ptr_q];

`ifdef IMM_GEN_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode vector table plus hand-written FIFO, flush and reset
// sequences.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_has_imm;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

`ifdef IMM_GEN_PERF_EN
    localparam int unsigned PerfOn = 1;
`else
    localparam int unsigned PerfOn = 0;
`endif

    imm_gen_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_imm    (out_imm),
        .out_has_imm(out_has_imm),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [15:0] instr, input logic [15:0] imm,
                            input logic has);
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " instr"}, 32'(out_instr), 32'(instr));
        chk({name, " imm"}, 32'(out_imm), 32'(imm));
        chk({name, " has"}, 32'(out_has_imm), 32'(has));
    endtask

    task automatic chk_empty(input string name);
        chk({name, " valid"}, 32'(out_valid), 32'd0);
        chk({name, " instr"}, 32'(out_instr), 32'd0);
        chk({name, " imm"}, 32'(out_imm), 32'd0);
        chk({name, " has"}, 32'(out_has_imm), 32'd0);
    endtask

    initial begin
        vecs.push_back('{16'h4015, 16'hFFF5, 1'b1});
        vecs.push_back('{16'h6080, 16'hFF80, 1'b1});
        vecs.push_back('{16'h2400, 16'hFC00, 1'b1});
        vecs.push_back('{16'h5015, 16'h0015, 1'b1});
        vecs.push_back('{16'h9080, 16'h0080, 1'b1});
        vecs.push_back('{16'h0800, 16'h0000, 1'b0});
        vecs.push_back('{16'h8017, 16'hFFF7, 1'b1});
        vecs.push_back('{16'hB01F, 16'h001F, 1'b1});
        vecs.push_back('{16'hC07F, 16'h007F, 1'b1});
        vecs.push_back('{16'h3400, 16'hFC00, 1'b1});
        vecs.push_back('{16'h37FF, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h2BFF, 16'hFFFF, 1'b1});
        vecs.push_back('{16'hF8FF, 16'h0000, 1'b0});
        vecs.push_back('{16'h9FFF, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h5805, 16'h0005, 1'b1});
        vecs.push_back('{16'h7A34, 16'h0034, 1'b1});
        vecs.push_back('{16'h3A55, 16'h0055, 1'b1});

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk_empty("rst out");
        chk("rst stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // Decode table: each instr goes through an empty FIFO with one cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            step();
            in_valid = 1'b0;
            chk_head($sformatf("vec%0d", i), vecs[i].instr, vecs[i].imm, vecs[i].has);
            step();
            chk_empty($sformatf("vec%0d drained", i));
        end

        // Backpressure: two accepted, third refused, drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h6080;
        step();
        in_instr = 16'h2400;
        step();
        chk("full in_ready", 32'(in_ready), 32'd0);
        in_instr = 16'h4015;
        step();
        in_valid = 1'b0;
        chk("stall count", 32'(stall_cnt), 32'(PerfOn));
        chk_head("held head", 16'h6080, 16'hFF80, 1'b1);
        out_ready = 1'b1;
        step();
        chk_head("drain 1", 16'h2400, 16'hFC00, 1'b1);
        step();
        chk_empty("drain 2");

        // Simultaneous enqueue and dequeue at count 1.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h5015;
        step();
        out_ready = 1'b1;
        in_instr  = 16'h9080;
        step();
        in_valid = 1'b0;
        chk_head("enq+deq", 16'h9080, 16'h0080, 1'b1);
        chk("enq+deq in_ready", 32'(in_ready), 32'd1);
        step();
        chk_empty("enq+deq drained");

        // Full with dequeue: no pass-through of the new instr.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h4015;
        step();
        in_instr = 16'h8017;
        step();
        out_ready = 1'b1;
        in_instr  = 16'hB01F;
        step();
        in_valid = 1'b0;
        chk_head("full deq", 16'h8017, 16'hFFF7, 1'b1);
        step();
        chk_empty("full deq drained");

        // Flush while full with a same-cycle push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h6080;
        step();
        in_instr = 16'h2400;
        step();
        flush    = 1'b1;
        in_instr = 16'h5015;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_empty("flush");
        chk("flush in_ready", 32'(in_ready), 32'd1);
        step();
        chk_empty("flush no store");
        in_valid = 1'b1;
        in_instr = 16'h9FFF;
        step();
        in_valid = 1'b0;
        chk_head("after flush", 16'h9FFF, 16'hFFFF, 1'b1);

        // Reset overrides flush with one entry buffered.
        rst   = 1'b1;
        flush = 1'b1;
        step();
        chk_empty("rst+flush");
        chk("rst+flush in_ready", 32'(in_ready), 32'd0);
        chk("rst+flush stall", 32'(stall_cnt), 32'd0);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_instr = 16'h4015;
        step();
        in_valid = 1'b0;
        chk_head("post-rst push", 16'h4015, 16'hFFF5, 1'b1);
        out_ready = 1'b1;
        step();
        chk_empty("final drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
